// File: rtl/ff_ctrl_pkg.sv
// Shared op codes and FSM state encoding for the flip-flop bank controller.
package ff_ctrl_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_CLEAR  = 3'd2;
    localparam logic [2:0] OP_SET    = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;
    localparam logic [2:0] OP_ROTL   = 3'd7;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Ops 5-7 step the bank repeatedly; everything below them completes in one edge.
    function automatic logic is_multi(input logic [2:0] op);
        return (op >= OP_CNT_UP);
    endfunction

endpackage

// File: rtl/ff_ctrl_datapath.sv
// Combinational next-value mux for the register bank, plus counter wrap detection.
module ff_ctrl_datapath
    import ff_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_next
);

    // Select the new bank value for the given op; wrap flags a count crossing the all-ones/zero boundary.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        case (op)
            OP_LOAD:   q_next = data;
            OP_CLEAR:  q_next = '0;
            OP_SET:    q_next = '1;
            OP_TOGGLE: q_next = q ^ data;
            OP_CNT_UP: begin
                q_next    = q + WIDTH'(1);
                wrap_next = (q == {WIDTH{1'b1}});
            end
            OP_CNT_DN: begin
                q_next    = q - WIDTH'(1);
                wrap_next = (q == {WIDTH{1'b0}});
            end
            OP_ROTL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/ff_bank_ctrl.sv
// Command sequencer for a flip-flop register bank: single-edge ops from IDLE,
// stepped multi-cycle ops in RUN with pause support and done/wrap pulses.
module ff_bank_ctrl
    import ff_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             pause,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    logic             state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    logic [2:0]       dp_op;
    logic [WIDTH-1:0] dp_q_next;
    logic             dp_wrap;

    // While running, the latched op drives the datapath; in IDLE the incoming command does.
    always_comb begin
        dp_op = (state_q == ST_RUN) ? op_q : cmd_op;
    end

    ff_ctrl_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .op        (dp_op),
        .q         (q_q),
        .data      (cmd_data),
        .q_next    (dp_q_next),
        .wrap_next (dp_wrap)
    );

    // Next-state logic: accept in IDLE, step and count down in RUN unless paused.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        q_d     = q_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (is_multi(cmd_op) && (cmd_len != '0)) begin
                        op_d    = cmd_op;
                        rem_d   = cmd_len;
                        state_d = ST_RUN;
                    end else begin
                        if (!is_multi(cmd_op)) begin
                            q_d = dp_q_next;
                        end
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    q_d    = dp_q_next;
                    wrap_d = dp_wrap;
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any op without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            op_q    <= OP_NOP;
            q_q     <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            q_q     <= q_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q         = q_q;
    assign busy      = (state_q == ST_RUN);
    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule
